// File: rtl/prog_loader_pkg.sv
// Shared constants for the serial instruction-memory loader.
// Framing byte, FSM encodings and bit-timing helper.
package prog_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEN  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_CSUM = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 serial byte receiver with input synchroniser.
// Start bit is re-checked at mid-bit to reject glitches.
module prog_loader_uart_rx
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    sync;
  logic          rx_s;
  logic [1:0]    st;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    shreg;

  assign rx_s = sync[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync       <= 2'b11;
      st         <= RX_IDLE;
      cnt        <= '0;
      bitn       <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      sync       <= {sync[0], rx};
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (st)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx_s) st <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt  <= '0;
            bitn <= '0;
            st   <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            bitn  <= bitn + 1'b1;
            if (bitn == 3'd7) st <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == FULL) begin
            cnt <= '0;
            st  <= RX_IDLE;
            if (rx_s) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/prog_loader.sv
// UART-fed instruction memory writer: frames, checksums and
// strobes words into instr_mem while holding the core in reset.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CLK_HZ       = 24000000,
  parameter int BAUD         = 115200,
  parameter int ADDR_W       = 8,
  parameter int INSTR_W      = 30,
  parameter int TIMEOUT_CLKS = 2400000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err,
  output logic [ADDR_W:0]    word_count
);

  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int TW  = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CLKS - 1);

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          frame_err;
  logic [2:0]    state;
  logic [1:0]    bcnt;
  logic [23:0]   asm_q;
  logic [7:0]    csum;
  logic [ADDR_W:0] nwords;
  logic [TW-1:0] tcnt;
  logic          active;
  logic          expire;
  logic [31:0]   word;

  prog_loader_uart_rx #(.CLKS_PER_BIT(CPB)) u_uart_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  assign active = (state == ST_LEN) || (state == ST_DATA) ||
                  (state == ST_CSUM);
  assign expire = active && (tcnt == T_LAST);
  assign word   = {asm_q, byte_data};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bcnt       <= '0;
      asm_q      <= '0;
      csum       <= '0;
      nwords     <= '0;
      tcnt       <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      word_count <= '0;
    end else begin
      wr_en     <= 1'b0;
      load_done <= 1'b0;
      if (wr_en) begin
        wr_addr    <= wr_addr + 1'b1;
        word_count <= word_count + 1'b1;
      end
      if (byte_valid || !active) tcnt <= '0;
      else tcnt <= tcnt + 1'b1;
      // timeout beats a same-cycle byte; that byte is dropped
      if (state == ST_ERR) begin
        load_err <= 1'b1;
        cpu_hold <= 1'b0;
        state    <= ST_IDLE;
      end else if (expire || (frame_err && state != ST_IDLE)) begin
        state <= ST_ERR;
      end else if (byte_valid) begin
        unique case (state)
          ST_IDLE: begin
            if (byte_data == SYNC_BYTE) begin
              state      <= ST_LEN;
              cpu_hold   <= 1'b1;
              load_err   <= 1'b0;
              word_count <= '0;
              csum       <= '0;
            end
          end
          ST_LEN: begin
            nwords  <= (byte_data == 8'd0) ? (ADDR_W+1)'(256)
                                           : (ADDR_W+1)'(byte_data);
            wr_addr <= '0;
            bcnt    <= '0;
            state   <= ST_DATA;
          end
          ST_DATA: begin
            asm_q <= word[23:0];
            csum  <= csum ^ byte_data;
            bcnt  <= bcnt + 1'b1;
            if (bcnt == 2'd3) begin
              if (|word[31:INSTR_W]) begin
                state <= ST_ERR;
              end else begin
                wr_en   <= 1'b1;
                wr_data <= word[INSTR_W-1:0];
                if (word_count + 1'b1 == nwords) state <= ST_CSUM;
              end
            end
          end
          default: begin
            if (byte_data == csum) begin
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              state <= ST_ERR;
            end
          end
        endcase
      end
    end
  end

endmodule
